// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loader_pkg
// Brief    : Shared state encoding and field widths for prog_loader.
//            The checksum states exist only when LOADER_CHECKSUM_EN is defined.
// Revision : 1.0
// ============================================================================
package loader_pkg;

    localparam int C_BYTE_W            = 8;
    localparam int C_WORD_W            = 16;
    localparam int C_DEFAULT_MAX_WORDS = 256;

    typedef enum logic [3:0] {
        ST_LEN_HI = 4'd0,
        ST_LEN_LO = 4'd1,
        ST_DAT_HI = 4'd2,
        ST_DAT_LO = 4'd3,
        ST_WRITE  = 4'd4,
        ST_DONE   = 4'd5,
        ST_ERR    = 4'd6
`ifdef LOADER_CHECKSUM_EN
        ,
        ST_CHK_HI = 4'd7,
        ST_CHK_LO = 4'd8
`endif
    } state_t;

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : word_assembler
// Brief    : Pairs consecutive accepted bytes (high first) into a 16-bit word;
//            o_word_valid pulses combinationally with the low byte.
// Revision : 1.0
// ============================================================================
module word_assembler
    import loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_accept,
    input  logic [C_BYTE_W-1:0] i_byte,
    output logic [C_WORD_W-1:0] o_word,
    output logic                o_word_valid
);

    logic                r_lo_next;
    logic [C_BYTE_W-1:0] r_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo_next <= 1'b0;
            r_hi      <= '0;
        end else if (i_accept) begin
            r_lo_next <= ~r_lo_next;
            if (!r_lo_next) begin
                r_hi <= i_byte;
            end
        end
    end

    assign o_word       = {r_hi, i_byte};
    assign o_word_valid = i_accept & r_lo_next;

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : Serial-link program loader: length-prefixed word frame written
//            into CPU memory while the CPU is held. Optional trailing 16-bit
//            sum check enabled by LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module prog_loader
    import loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = C_DEFAULT_MAX_WORDS
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [16:0] C_MAX = 17'(MAX_WORDS);

    state_t      r_state;
    logic [15:0] r_idx;
    logic [15:0] r_count;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_cpu_hold;
    logic        r_done;
    logic        r_error;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] r_csum;
`endif

    logic        w_ready_state;
    logic        w_accept;
    logic        w_word_valid;
    logic [15:0] w_word;

    always_comb begin
        w_ready_state = 1'b0;
        case (r_state)
            ST_LEN_HI, ST_LEN_LO, ST_DAT_HI, ST_DAT_LO: w_ready_state = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            ST_CHK_HI, ST_CHK_LO:                       w_ready_state = 1'b1;
`endif
            default:                                    w_ready_state = 1'b0;
        endcase
    end

    // Masked by reset so no byte can be consumed while the loader is being cleared.
    assign rx_ready = w_ready_state & ~reset;
    assign w_accept = rx_valid & rx_ready;

    word_assembler u_word_assembler (
        .clk          (CLK),
        .rst          (reset),
        .i_accept     (w_accept),
        .i_byte       (rx_byte),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state     <= ST_LEN_HI;
            r_idx       <= '0;
            r_count     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                ST_LEN_HI: if (w_accept) r_state <= ST_LEN_LO;
                ST_LEN_LO: if (w_word_valid) begin
                    r_count <= w_word;
                    if ({1'b0, w_word} > C_MAX) begin
                        r_state <= ST_ERR;
                        r_error <= 1'b1;
                    end else if (w_word == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state    <= ST_CHK_HI;
`else
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
`endif
                    end else begin
                        r_state <= ST_DAT_HI;
                    end
                end
                ST_DAT_HI: if (w_accept) r_state <= ST_DAT_LO;
                ST_DAT_LO: if (w_word_valid) begin
                    r_state     <= ST_WRITE;
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= BASE_ADDR + r_idx;
                    r_mem_wdata <= w_word;
`ifdef LOADER_CHECKSUM_EN
                    r_csum      <= r_csum + w_word;
`endif
                end
                ST_WRITE: begin
                    r_idx <= r_idx + 16'd1;
                    if (r_idx + 16'd1 == r_count) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state    <= ST_CHK_HI;
`else
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
`endif
                    end else begin
                        r_state <= ST_DAT_HI;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHK_HI: if (w_accept) r_state <= ST_CHK_LO;
                ST_CHK_LO: if (w_word_valid) begin
                    if (w_word == r_csum) begin
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end else begin
                        r_state <= ST_ERR;
                        r_error <= 1'b1;
                    end
                end
`endif
                default: r_state <= r_state;
            endcase
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;
    assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Brief    : Randomized self-checking bench for prog_loader (handles the
//            LOADER_CHECKSUM_EN build as well).
// Revision : 1.0
// ============================================================================
module tb_prog_loader;

    localparam logic [15:0] TB_BASE = 16'hFFFF;
    localparam int          TB_MAX  = 256;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_ready, mem_we, cpu_hold, done, error;
    logic [15:0] mem_addr, mem_wdata;

    prog_loader #(.BASE_ADDR(TB_BASE), .MAX_WORDS(TB_MAX)) dut (
        .CLK(CLK), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: frame parsed from accepted bytes
    logic [7:0]  fb[$];
    logic [31:0] wlog[$];
    int          m_n = 0;
    logic [15:0] m_sum = 16'h0;
    logic        e_we = 1'b0, e_done = 1'b0, e_err = 1'b0, e_ready = 1'b0;
    logic [15:0] e_addr = 16'h0, e_wdata = 16'h0;
    bit          m_live = 1'b0, reset_prev = 1'b0;
    int          cyc = 0, last_acc_cyc = 0, done_cyc = -1;

    task automatic model_step();
        int p;
        logic [15:0] w;
        if (e_we) begin
            e_we = 1'b0;
            if ((fb.size() - 2) / 2 == m_n) begin
`ifdef LOADER_CHECKSUM_EN
                e_ready = 1'b1;
`else
                e_done  = 1'b1;
                e_ready = 1'b0;
`endif
            end else begin
                e_ready = 1'b1;
            end
        end else if (rx_valid && e_ready) begin
            fb.push_back(rx_byte);
            p = fb.size() - 1;
            last_acc_cyc = cyc;
            if (p == 1) begin
                m_n = int'({fb[0], fb[1]});
                if (m_n > TB_MAX) begin
                    e_err = 1'b1; e_ready = 1'b0;
                end else if (m_n == 0) begin
`ifndef LOADER_CHECKSUM_EN
                    e_done = 1'b1; e_ready = 1'b0;
`endif
                end
            end else if (p <= 2 * m_n + 1) begin
                if (p % 2 == 1) begin
                    w = {fb[p-1], fb[p]};
                    e_we = 1'b1;
                    e_addr = TB_BASE + 16'((p - 3) / 2);
                    e_wdata = w;
                    m_sum = m_sum + w;
                    e_ready = 1'b0;
                end
            end else if (p == 2 * m_n + 3) begin
                w = {fb[p-1], fb[p]};
                if (w == m_sum) e_done = 1'b1;
                else            e_err  = 1'b1;
                e_ready = 1'b0;
            end
        end
    endtask

    always @(negedge CLK) begin
        cyc++;
        if (reset) begin
            check("rx_ready_in_reset", {31'd0, rx_ready}, 32'd0);
            if (reset_prev) begin
                check("rst_mem_we",    {31'd0, mem_we},   32'd0);
                check("rst_mem_addr",  {16'd0, mem_addr}, 32'd0);
                check("rst_mem_wdata", {16'd0, mem_wdata},32'd0);
                check("rst_cpu_hold",  {31'd0, cpu_hold}, 32'd1);
                check("rst_done",      {31'd0, done},     32'd0);
                check("rst_error",     {31'd0, error},    32'd0);
            end
            fb.delete(); wlog.delete();
            m_n = 0; m_sum = 16'h0;
            e_we = 1'b0; e_addr = 16'h0; e_wdata = 16'h0;
            e_done = 1'b0; e_err = 1'b0; e_ready = 1'b1;
            m_live = 1'b1; done_cyc = -1;
        end else if (m_live) begin
            check("rx_ready",  {31'd0, rx_ready}, {31'd0, e_ready});
            check("mem_we",    {31'd0, mem_we},   {31'd0, e_we});
            check("mem_addr",  {16'd0, mem_addr}, {16'd0, e_addr});
            check("mem_wdata", {16'd0, mem_wdata},{16'd0, e_wdata});
            check("done",      {31'd0, done},     {31'd0, e_done});
            check("error",     {31'd0, error},    {31'd0, e_err});
            check("cpu_hold",  {31'd0, cpu_hold}, {31'd0, ~e_done});
            if (mem_we) wlog.push_back({mem_addr, mem_wdata});
            if (done && done_cyc < 0) done_cyc = cyc;
            model_step();
        end
        reset_prev = reset;
    end

    // ---------------- stimulus
    logic [15:0] wq[$];
    logic [7:0]  bq[$];

    task automatic send_byte(input logic [7:0] b, input int pct);
        int  waited = 0;
        bit  acc = 1'b0;
        while (!acc) begin
            rx_valid = ($urandom_range(99) < pct);
            rx_byte  = rx_valid ? b : 8'($urandom);
            @(negedge CLK);
            acc = rx_valid && rx_ready;
            @(posedge CLK);
            #1;
            waited++;
            if (!acc && waited > 300) begin
                n_tests++; n_fail++;
                $display("FAIL byte_accept_timeout: got no accept of %h, required accept within 300 cycles", b);
                rx_valid = 1'b0;
                return;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_bq(input int pct);
        foreach (bq[i]) send_byte(bq[i], pct);
    endtask

    task automatic send_words(input int pct, input bit good_csum);
        logic [15:0] s = 16'h0;
        send_byte(8'(wq.size() >> 8), pct);
        send_byte(8'(wq.size()), pct);
        foreach (wq[i]) begin
            send_byte(wq[i][15:8], pct);
            send_byte(wq[i][7:0], pct);
            s = s + wq[i];
        end
`ifdef LOADER_CHECKSUM_EN
        if (!good_csum) s = s ^ 16'h0100;
        send_byte(s[15:8], pct);
        send_byte(s[7:0], pct);
`else
        if (good_csum) s = s + 16'h0;
`endif
    endtask

    task automatic idle(input int n, input bit offer);
        repeat (n) begin
            rx_valid = offer;
            rx_byte  = 8'($urandom);
            @(posedge CLK);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge CLK);
        #1;
        reset = 1'b0;

        // Two-word frame, base address wraps from 0xFFFF to 0x0000
        wq = '{16'h1234, 16'hABCD};
        send_words(60, 1'b1);
        idle(5, 1'b1);
        check("two_word_count", wlog.size(), 32'd2);
        if (wlog.size() == 2) begin
            check("two_word_w0", wlog[0], {16'hFFFF, 16'h1234});
            check("two_word_w1", wlog[1], {16'h0000, 16'hABCD});
        end
        check("two_word_done", {31'd0, done}, 32'd1);
        check("two_word_hold", {31'd0, cpu_hold}, 32'd0);

        // Empty frame
        do_reset();
        wq.delete();
        send_words(100, 1'b1);
        idle(4, 1'b1);
        check("empty_writes", wlog.size(), 32'd0);
        check("empty_done", {31'd0, done}, 32'd1);
        check("empty_done_latency", ((done_cyc - last_acc_cyc) >= 1 && (done_cyc - last_acc_cyc) <= 2) ? 32'd1 : 32'd0, 32'd1);

        // Over-long count 0x0101
        do_reset();
        bq = '{8'h01, 8'h01};
        send_bq(100);
        idle(5, 1'b1);
        check("overlong_error", {31'd0, error}, 32'd1);
        check("overlong_writes", wlog.size(), 32'd0);
        check("overlong_hold", {31'd0, cpu_hold}, 32'd1);

        // rx_valid held high throughout
        do_reset();
        wq = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
        send_words(100, 1'b1);
        idle(4, 1'b0);
        check("stream_count", wlog.size(), 32'd4);
        if (wlog.size() == 4) check("stream_w3", wlog[3], {16'h0002, 16'h0708});

        // Reset mid-frame, then a fresh one-word frame
        do_reset();
        bq = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB};
        send_bq(100);
        idle(3, 1'b0);
        check("midframe_count", wlog.size(), 32'd1);
        if (wlog.size() == 1) check("midframe_w0", wlog[0], {16'hFFFF, 16'h1234});
        do_reset();
        wq = '{16'h55AA};
        send_words(80, 1'b1);
        idle(4, 1'b0);
        check("after_reset_count", wlog.size(), 32'd1);
        if (wlog.size() == 1) check("after_reset_w0", wlog[0], {TB_BASE, 16'h55AA});
        check("after_reset_done", {31'd0, done}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        bq = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h04};
        send_bq(100);
        idle(4, 1'b1);
        check("csum_bad_error", {31'd0, error}, 32'd1);
        check("csum_bad_writes", wlog.size(), 32'd2);
        do_reset();
        bq = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
        send_bq(100);
        idle(4, 1'b1);
        check("csum_good_done", {31'd0, done}, 32'd1);
`endif

        // Exactly MAX_WORDS words
        do_reset();
        wq.delete();
        for (int i = 0; i < TB_MAX; i++) wq.push_back(16'($urandom));
        send_words(100, 1'b1);
        idle(4, 1'b0);
        check("max_count", wlog.size(), 32'd256);
        check("max_done", {31'd0, done}, 32'd1);

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            do_reset();
            if ($urandom_range(0, 5) == 0) begin
                n = 257 + $urandom_range(0, 1000);
                bq = '{8'(n >> 8), 8'(n)};
                send_bq($urandom_range(30, 100));
            end else begin
                n = $urandom_range(0, 10);
                wq.delete();
                for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
                send_words($urandom_range(30, 100), 1'($urandom_range(0, 1)));
            end
            idle(6, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_tests++; n_fail++;
        $display("FAIL watchdog: got no finish, required finish before 1 ms");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000: memory address of the first loaded word.
REQ-002 Parameter MAX_WORDS, default 256: largest accepted word count.
REQ-003 Port CLK, input, 1: single clock; all logic on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port rx_valid, input, 1: a byte is offered on rx_byte.
REQ-006 Port rx_byte, input, 8: serial-link byte.
REQ-007 Port rx_ready, output, 1: the loader can accept a byte.
REQ-008 Port mem_we, output, 1: single-cycle write strobe to the CPU memory.
REQ-009 Port mem_addr, output, 16: write address.
REQ-010 Port mem_wdata, output, 16: write data.
REQ-011 Port cpu_hold, output, 1: keeps the CPU in reset while high; top level drives CPU reset = reset | cpu_hold.
REQ-012 Port done, output, 1: load completed successfully.
REQ-013 Port error, output, 1: load aborted.

Function
REQ-014 A byte SHALL be accepted only on a cycle with rx_valid && rx_ready.
REQ-015 Frame format SHALL be: count high byte, count low byte, then N words, each sent high byte first.
REQ-016 States SHALL be LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, DONE, ERR.
- LEN_HI -> LEN_LO on accept.
- LEN_LO -> DAT_HI on accept.
- DAT_HI -> DAT_LO on accept.
- DAT_LO -> WRITE on accept.
- WRITE -> DAT_HI when words remain, else -> DONE.
REQ-017 rx_ready SHALL be 1 in LEN_HI, LEN_LO, DAT_HI and DAT_LO, and 0 in all other states.
REQ-018 mem_we SHALL be high for exactly the one WRITE cycle, which follows the cycle in which the DAT_LO byte is accepted.
REQ-019 In that WRITE cycle, mem_addr SHALL be BASE_ADDR + idx, with 16-bit wrap, and mem_wdata SHALL be {hi, lo}.
REQ-020 idx SHALL increment after each WRITE.
REQ-021 Count N = 0 SHALL go from LEN_LO directly to DONE (or to the checksum states when LOADER_CHECKSUM_EN is defined) with no writes.
REQ-022 Count N > MAX_WORDS SHALL go from LEN_LO to ERR with no writes.
REQ-023 cpu_hold SHALL be 1 in every state except DONE.
REQ-024 done SHALL be 1 only in DONE; error SHALL be 1 only in ERR.
REQ-025 DONE and ERR SHALL be terminal until reset.
REQ-026 rx_valid SHALL be ignored while rx_ready = 0; bytes offered then are not consumed.
REQ-027 mem_addr and mem_wdata SHALL hold their last values when mem_we = 0.

Reset
REQ-028 While reset is high at a rising edge, the loader SHALL return to state LEN_HI, clear idx, count and checksum, and drive rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0.
REQ-029 Reset mid-frame SHALL discard the partial frame with no further writes; words already written remain in memory.

Configuration
REQ-030 With LOADER_CHECKSUM_EN defined:
- After the last WRITE, the loader SHALL go to states CHK_HI then CHK_LO, accepting a 2-byte checksum, high byte first.
- The checksum is the 16-bit modulo-2^16 sum of all data words.
- Match -> DONE; mismatch -> ERR (data remains written, cpu_hold stays 1).
REQ-031 Without LOADER_CHECKSUM_EN, the CHK states and the accumulator SHALL be absent, and the frame ends after the last data word.

Structure
REQ-032 Package loader_pkg SHALL hold the state enum typedef, the byte-pair constants and the default MAX_WORDS.
REQ-033 One sub-module, word_assembler, SHALL pair accepted bytes into a 16-bit word with a word_valid pulse.
- It is reused for the count, data and checksum fields.

Verification
REQ-034 Frame 00 02 12 34 AB CD -> writes 0x1234 to addr 0 and 0xABCD to addr 1; done=1, cpu_hold=0.
REQ-035 Frame 00 00 -> no mem_we pulses; done=1 two cycles after the second byte (checksum build: after 00 00 00 00).
REQ-036 Count 0x0101 with MAX_WORDS=256 -> error=1, no writes, cpu_hold=1.
REQ-037 rx_valid held high throughout -> rx_ready=0 during WRITE; no byte lost or duplicated; word order preserved.
REQ-038 reset asserted after 00 03 12 34 AB -> outputs return to reset values; a following frame 00 01 55 AA writes 0x55AA to BASE_ADDR.
REQ-039 Checksum build, frame 00 02 00 01 00 02 00 04 -> error=1; the same frame ending 00 03 -> done=1.
